// File: rtl/divu_remu_seq.sv
// Multi-cycle 64-bit unsigned DIVU/REMU unit: one restoring shift-compare-subtract
// step per cycle, with an optional one-cycle short-circuit for divide-by-zero.

module set_less_than_unsigned (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        lt_o
);
  assign lt_o = (a_i < b_i);
endmodule

// Handshake: start is accepted only on an edge where ready=1 and kill=0; the
// result is valid for exactly the single cycle in which done=1 and is then held
// on result until the next operation completes.
module divu_remu_seq #(
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic        is_rem,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] quo_q, quo_d;
  logic [64:0] rem_q, rem_d;
  logic [63:0] div_q, div_d;
  logic        is_rem_q, is_rem_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] result_q, result_d;

  logic [64:0] s;
  logic        lt;
  logic        ge;
  logic [64:0] rem_step;
  logic [63:0] quo_step;

  // s[64] set means the shifted remainder already exceeds any 64-bit divisor.
  assign s = {rem_q[63:0], quo_q[63]};

  set_less_than_unsigned u_slt (
    .a_i  (s[63:0]),
    .b_i  (div_q),
    .lt_o (lt)
  );

  assign ge       = s[64] | ~lt;
  assign rem_step = ge ? (s - {1'b0, div_q}) : s;
  assign quo_step = {quo_q[62:0], ge};

  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    is_rem_d = is_rem_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          div_d    = divisor;
          is_rem_d = is_rem;
          quo_d    = dividend;
          rem_d    = '0;
          count_d  = 6'd63;
          state_d  = S_RUN;
          if (ZERO_FAST && (divisor == 64'd0)) begin
            quo_d    = '1;
            rem_d    = {1'b0, dividend};
            result_d = is_rem ? dividend : '1;
            state_d  = S_DONE;
          end
        end
      end
      S_RUN: begin
        quo_d   = quo_step;
        rem_d   = rem_step;
        count_d = count_q - 6'd1;
        if (count_q == 6'd0) begin
          result_d = is_rem_q ? rem_step[63:0] : quo_step;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A flushed operation must never publish a result.
    if (kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      is_rem_q <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      is_rem_q <= is_rem_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
